// File: rtl/alu16_pkg.sv
// Shared types for the ALU16 golden model and result checker.
package alu16_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpAdd  = 3'b010,
        OpRsvd = 3'b011,
        OpAndn = 3'b100,
        OpOrn  = 3'b101,
        OpSub  = 3'b110,
        OpSlt  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } checker_state_t;

endpackage

// File: rtl/alu16_ref_model.sv
// Combinational ALU16 golden function (a, b, op) -> y_exp.
// ALU16_CHECK_ZERO_EN adds the expected zero flag output.
module alu16_ref_model
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
`ifdef ALU16_CHECK_ZERO_EN
    output logic             zero_exp,
`endif
    output logic [WIDTH-1:0] y_exp
);

    always_comb begin
        y_exp = '0;
        case (op)
            OpAnd:   y_exp = a & b;
            OpOr:    y_exp = a | b;
            OpAdd:   y_exp = a + b;
            OpAndn:  y_exp = a & ~b;
            OpOrn:   y_exp = a | ~b;
            OpSub:   y_exp = a - b;
            OpSlt:   y_exp = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y_exp = '0;
        endcase
    end

`ifdef ALU16_CHECK_ZERO_EN
    assign zero_exp = (y_exp == '0);
`endif

endmodule

// File: rtl/alu16_result_checker.sv
// On-chip ALU16 result checker: compares a transaction stream against a golden model.
// ALU16_CHECK_ZERO_EN adds zero-flag checking (zero_obs in, first_fail_zero out).
module alu16_result_checker
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] y_obs,
`ifdef ALU16_CHECK_ZERO_EN
    input  logic             zero_obs,
    output logic             first_fail_zero,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_obs
);

    checker_state_t   state_q;
    logic [CNT_W-1:0] num_q, acc_cnt_q, idx_q;
    logic             cmp_valid_q;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    alu_op_t          op_q;
    logic [WIDTH-1:0] y_exp;
    logic             mismatch, accept;
    logic [CNT_W-1:0] pass_d, fail_d;
`ifdef ALU16_CHECK_ZERO_EN
    logic             zero_q, zero_exp;
`endif

    alu16_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
`ifdef ALU16_CHECK_ZERO_EN
        .zero_exp (zero_exp),
`endif
        .y_exp    (y_exp)
    );

    assign in_ready = (state_q == StRun);
    assign accept   = in_valid & in_ready;

    always_comb begin
`ifdef ALU16_CHECK_ZERO_EN
        mismatch = cmp_valid_q & ((y_exp != y_q) | (zero_exp != zero_q));
`else
        mismatch = cmp_valid_q & (y_exp != y_q);
`endif
        pass_d = pass_count;
        fail_d = fail_count;
        // Counters stick at all-ones rather than wrapping.
        if (cmp_valid_q) begin
            if (mismatch) begin
                if (fail_count != '1) fail_d = fail_count + CNT_W'(1);
            end else begin
                if (pass_count != '1) pass_d = pass_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            num_q          <= '0;
            acc_cnt_q      <= '0;
            idx_q          <= '0;
            cmp_valid_q    <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            y_q            <= '0;
            op_q           <= OpAnd;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_obs <= '0;
`ifdef ALU16_CHECK_ZERO_EN
            zero_q          <= 1'b0;
            first_fail_zero <= 1'b0;
`endif
        end else begin
            pass_count  <= pass_d;
            fail_count  <= fail_d;
            cmp_valid_q <= accept;
            if (mismatch && fail_count == '0) begin
                first_fail_idx <= idx_q;
                first_fail_exp <= y_exp;
                first_fail_obs <= y_q;
`ifdef ALU16_CHECK_ZERO_EN
                first_fail_zero <= zero_q;
`endif
            end
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                op_q      <= alu_op_t'(op);
                y_q       <= y_obs;
                idx_q     <= acc_cnt_q;
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
`ifdef ALU16_CHECK_ZERO_EN
                zero_q    <= zero_obs;
`endif
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        num_q          <= num_vectors;
                        acc_cnt_q      <= '0;
                        pass_count     <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_exp <= '0;
                        first_fail_obs <= '0;
`ifdef ALU16_CHECK_ZERO_EN
                        first_fail_zero <= 1'b0;
`endif
                        if (num_vectors == '0) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            pass    <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (accept && (acc_cnt_q + CNT_W'(1)) == num_q) state_q <= StDrain;
                end
                StDrain: begin
                    // The final compare retires on this edge, so fold it into pass.
                    if (cmp_valid_q) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (fail_d == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_result_checker.sv
// Directed self-checking bench for alu16_result_checker (ALU16_CHECK_ZERO_EN aware).
module tb_alu16_result_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_vectors = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0, y_obs = '0;
    logic [2:0]  op = '0;
    logic        zero_obs = 1'b0;
    logic        first_fail_zero;
    logic        busy, done, pass;
    logic [15:0] pass_count, fail_count, first_fail_idx, first_fail_exp, first_fail_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifndef ALU16_CHECK_ZERO_EN
    assign first_fail_zero = 1'b0;
`endif

    alu16_result_checker #(
        .WIDTH (16),
        .CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_vectors     (num_vectors),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .op              (op),
        .y_obs           (y_obs),
`ifdef ALU16_CHECK_ZERO_EN
        .zero_obs        (zero_obs),
        .first_fail_zero (first_fail_zero),
`endif
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .first_fail_idx  (first_fail_idx),
        .first_fail_exp  (first_fail_exp),
        .first_fail_obs  (first_fail_obs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [15:0] n);
        num_vectors = n;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] r, input logic z);
        int n;
        op = o; a = x; b = y; y_obs = r; zero_obs = z;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_flags", {in_ready, busy, done, pass}, 4'b0000);
        check("rst_counts", {pass_count, fail_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a run after 3 accepts
        do_start(16'd5);
        check("run_busy", busy, 1'b1);
        check("run_ready", in_ready, 1'b1);
        send(3'b010, 16'h0003, 16'h0005, 16'h0008, 1'b0);
        send(3'b010, 16'h0003, 16'h0005, 16'h0001, 1'b0);
        send(3'b010, 16'h0003, 16'h0005, 16'h0008, 1'b0);
        check("mid_fail_cnt", fail_count, 16'd1);
        reset = 1'b1;
        #1;
        check("mrst_flags", {in_ready, busy, done, pass}, 4'b0000);
        check("mrst_counts", {pass_count, fail_count}, 32'd0);
        check("mrst_first", {first_fail_idx, first_fail_obs}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_idle_ready", in_ready, 1'b0);

        // All four vectors correct
        do_start(16'd4);
        send(3'b010, 16'h0003, 16'h0005, 16'h0008, 1'b0);
        send(3'b110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        send(3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        send(3'b111, 16'h8000, 16'h0001, 16'h0001, 1'b0);
        check("ok_drain_done", done, 1'b0);
        check("ok_drain_ready", in_ready, 1'b0);
        @(negedge clk);
        check("ok_done", done, 1'b1);
        check("ok_busy", busy, 1'b0);
        check("ok_pass", pass, 1'b1);
        check("ok_pass_cnt", pass_count, 16'd4);
        check("ok_fail_cnt", fail_count, 16'd0);

        // Same vectors, idx 1 and 3 wrong
        do_start(16'd4);
        check("rerun_cleared", {done, pass_count}, 17'd0);
        send(3'b010, 16'h0003, 16'h0005, 16'h0008, 1'b0);
        send(3'b110, 16'h0005, 16'h0007, 16'h0000, 1'b1);
        send(3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        send(3'b111, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        @(negedge clk);
        check("bad_done", done, 1'b1);
        check("bad_pass", pass, 1'b0);
        check("bad_fail_cnt", fail_count, 16'd2);
        check("bad_pass_cnt", pass_count, 16'd2);
        check("bad_ff_idx", first_fail_idx, 16'd1);
        check("bad_ff_exp", first_fail_exp, 16'hFFFE);
        check("bad_ff_obs", first_fail_obs, 16'h0000);

        // Zero-length run
        in_valid = 1'b1;
        do_start(16'd0);
        check("zero_done", done, 1'b1);
        check("zero_pass", pass, 1'b1);
        check("zero_ready", in_ready, 1'b0);
        idle(2);
        check("zero_ignored", {pass_count, fail_count}, 32'd0);
        in_valid = 1'b0;

        // Gapped valid, second start ignored, add wrap, reserved op
        do_start(16'd4);
        send(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        num_vectors = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(3'b001, 16'h1200, 16'h0034, 16'h1234, 1'b0);
        idle(1);
        send(3'b111, 16'h0001, 16'h8000, 16'h0000, 1'b1);
        idle(1);
        send(3'b011, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        @(negedge clk);
        check("gap_done", done, 1'b1);
        check("gap_pass", pass, 1'b1);
        check("gap_pass_cnt", pass_count, 16'd4);
        in_valid = 1'b1;
        idle(2);
        in_valid = 1'b0;
        check("gap_done_ignore", {pass_count, fail_count}, {16'd4, 16'd0});

        // AND-NOT / OR-NOT, single mismatch at index 0
        do_start(16'd2);
        send(3'b100, 16'hFF00, 16'h0F0F, 16'hF00F, 1'b0);
        send(3'b101, 16'h0000, 16'hFFFE, 16'h0001, 1'b0);
        @(negedge clk);
        check("nb_fail_cnt", fail_count, 16'd1);
        check("nb_ff_idx", first_fail_idx, 16'd0);
        check("nb_ff_exp", first_fail_exp, 16'hF000);
        check("nb_ff_obs", first_fail_obs, 16'hF00F);

`ifdef ALU16_CHECK_ZERO_EN
        // Correct result, wrong zero flag
        do_start(16'd1);
        send(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        @(negedge clk);
        check("zf_fail_cnt", fail_count, 16'd1);
        check("zf_pass", pass, 1'b0);
        check("zf_ff_zero", first_fail_zero, 1'b0);
        check("zf_ff_exp", first_fail_exp, 16'h0000);
        // Wrong result with a set flag shows the captured observed flag
        do_start(16'd1);
        send(3'b000, 16'h00F0, 16'h0F00, 16'h0001, 1'b1);
        @(negedge clk);
        check("zf2_ff_zero", first_fail_zero, 1'b1);
`else
        check("nz_ff_zero", first_fail_zero, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
